// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: arms the timer, arbitrates module strikes round-robin onto
// the extras bus, polls seconds-left and declares EXPLODED or DEFUSED.
`timescale 1ns/1ps
module bomb_game_ctrl #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned MAX_STRIKES = 3,
    parameter int unsigned START_SEC   = 300,
    parameter int unsigned POLL_CYCLES = 1000,
    parameter logic [15:0] TIMER_ADDR  = 16'hF330,
    parameter logic [15:0] STRIKE_ADDR = 16'hF663
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_MODULES-1:0] strike_req,
    input  logic [NUM_MODULES-1:0] solved,
    output logic                   bus_en,
    output logic                   bus_we,
    output logic                   bus_re,
    output logic [15:0]            bus_addr,
    output logic [15:0]            bus_data,
    input  logic [15:0]            bus_q,
    output logic [1:0]             strikes,
    output logic [15:0]            sec_left,
    output logic [2:0]             game_state,
    output logic                   exploded,
    output logic                   defused
);

    localparam int unsigned PTR_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
    localparam int unsigned CNT_W = $clog2(POLL_CYCLES);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_MODULES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM_T    = 3'd1,
        S_ARM_S    = 3'd2,
        S_RUN      = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_EXPLODED = 3'd5,
        S_DEFUSED  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MODULES-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             strikes_q, strikes_d;
    logic [15:0]            sec_left_q, sec_left_d;
    logic                   exploded_q, exploded_d;
    logic                   defused_q, defused_d;

    logic                   found_c;
    logic [PTR_W-1:0]       grant_idx_c;
    logic [1:0]             strikes_inc_c;
    logic [NUM_MODULES-1:0] capture_c;
    logic                   all_solved_c;
    int unsigned            cand;

    assign capture_c     = strike_req & ~solved;
    assign all_solved_c  = &solved;
    assign strikes_inc_c = (strikes_q == 2'd3) ? 2'd3 : strikes_q + 2'd1;

    // Round-robin search: first pending index at or after the pointer, wrapping.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        cand        = 0;
        for (int unsigned off = 0; off < NUM_MODULES; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= NUM_MODULES) begin
                cand = cand - NUM_MODULES;
            end
            if (!found_c && pending_q[cand[PTR_W-1:0]]) begin
                found_c     = 1'b1;
                grant_idx_c = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        strikes_d  = strikes_q;
        sec_left_d = sec_left_q;
        bus_we     = 1'b0;
        bus_re     = 1'b0;
        bus_addr   = 16'd0;
        bus_data   = 16'd0;

        case (state_q)
            S_IDLE: begin
                pending_d = '0;
                if (start) state_d = S_ARM_T;
            end
            S_ARM_T: begin
                bus_we     = 1'b1;
                bus_addr   = TIMER_ADDR;
                bus_data   = 16'(START_SEC);
                sec_left_d = 16'(START_SEC);
                pending_d  = '0;
                state_d    = S_ARM_S;
            end
            S_ARM_S: begin
                bus_we    = 1'b1;
                bus_addr  = STRIKE_ADDR;
                strikes_d = 2'd0;
                cnt_d     = '0;
                pending_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (found_c) begin
                    // Clear the granted bit before merging new requests so a
                    // coincident request from the same module re-arms it.
                    pending_d              = pending_q;
                    pending_d[grant_idx_c] = 1'b0;
                    pending_d              = pending_d | capture_c;
                    ptr_d     = (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + PTR_W'(1);
                    strikes_d = strikes_inc_c;
                    bus_we    = 1'b1;
                    bus_addr  = STRIKE_ADDR;
                    bus_data  = 16'(strikes_inc_c);
                    if (32'(strikes_inc_c) >= MAX_STRIKES) state_d = S_EXPLODED;
                end else begin
                    pending_d = pending_q | capture_c;
                    if (cnt_q == POLL_LAST) begin
                        bus_re   = 1'b1;
                        bus_addr = TIMER_ADDR;
                        cnt_d    = '0;
                        state_d  = S_RD_WAIT;
                    end else if (all_solved_c) begin
                        state_d = S_DEFUSED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RD_WAIT: begin
                pending_d  = pending_q | capture_c;
                sec_left_d = bus_q;
                if (bus_q == 16'd0)    state_d = S_EXPLODED;
                else if (all_solved_c) state_d = S_DEFUSED;
                else                   state_d = S_RUN;
            end
            S_EXPLODED, S_DEFUSED: begin
                pending_d = '0;
                if (start) state_d = S_ARM_T;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_en     = bus_we | bus_re;
    assign exploded_d = (state_d == S_EXPLODED);
    assign defused_d  = (state_d == S_DEFUSED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            strikes_q  <= 2'd0;
            sec_left_q <= 16'd0;
            exploded_q <= 1'b0;
            defused_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            strikes_q  <= strikes_d;
            sec_left_q <= sec_left_d;
            exploded_q <= exploded_d;
            defused_q  <= defused_d;
        end
    end

    assign strikes    = strikes_q;
    assign sec_left   = sec_left_q;
    assign game_state = state_q;
    assign exploded   = exploded_q;
    assign defused    = defused_q;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Scoreboard bench for bomb_game_ctrl: instance A (default poll period) covers arm,
// strikes and defuse; instance B (POLL_CYCLES=4) covers polling and mid-read reset.
`timescale 1ns/1ps
module tb_bomb_game_ctrl;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_t;

    localparam logic [15:0] TA = 16'hF330;
    localparam logic [15:0] SA = 16'hF663;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic        rst_a, start_a, en_a, we_a, re_a, expl_a, def_a;
    logic [3:0]  req_a, solved_a;
    logic [15:0] addr_a, data_a, q_a, sec_a;
    logic [1:0]  strikes_a;
    logic [2:0]  st_a;

    logic        rst_b, start_b, en_b, we_b, re_b, expl_b, def_b;
    logic [3:0]  req_b, solved_b;
    logic [15:0] addr_b, data_b, q_b, sec_b;
    logic [1:0]  strikes_b;
    logic [2:0]  st_b;

    bus_t        qa[$];
    bus_t        qb[$];
    logic [15:0] rd_vals[$];
    bus_t        ea, eb;

    bomb_game_ctrl dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .strike_req(req_a), .solved(solved_a),
        .bus_en(en_a), .bus_we(we_a), .bus_re(re_a), .bus_addr(addr_a), .bus_data(data_a),
        .bus_q(q_a), .strikes(strikes_a), .sec_left(sec_a), .game_state(st_a),
        .exploded(expl_a), .defused(def_a)
    );

    bomb_game_ctrl #(.POLL_CYCLES(4)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .strike_req(req_b), .solved(solved_b),
        .bus_en(en_b), .bus_we(we_b), .bus_re(re_b), .bus_addr(addr_b), .bus_data(data_b),
        .bus_q(q_b), .strikes(strikes_b), .sec_left(sec_b), .game_state(st_b),
        .exploded(expl_b), .defused(def_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bus_t wr(input logic [15:0] a, input logic [15:0] d);
        return '{we: 1'b1, re: 1'b0, addr: a, data: d};
    endfunction

    function automatic bus_t rd(input logic [15:0] a);
        return '{we: 1'b0, re: 1'b1, addr: a, data: 16'd0};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Timer read-data model for instance B: answers one cycle after each read strobe.
    always @(posedge clk) begin
        if (re_b) begin
            if (rd_vals.size() > 0) q_b <= rd_vals.pop_front();
            else                    q_b <= 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        if (en_a || we_a || re_a) begin
            if (qa.size() == 0) begin
                chk("busA_unexpected", {en_a, we_a, re_a, addr_a, data_a}, 64'd0);
            end else begin
                ea = qa.pop_front();
                chk("busA", {en_a, we_a, re_a, addr_a, data_a}, {1'b1, ea});
            end
        end
    end

    always @(negedge clk) begin
        if (en_b || we_b || re_b) begin
            if (qb.size() == 0) begin
                chk("busB_unexpected", {en_b, we_b, re_b, addr_b, data_b}, 64'd0);
            end else begin
                eb = qb.pop_front();
                chk("busB", {en_b, we_b, re_b, addr_b, data_b}, {1'b1, eb});
            end
        end
    end

    initial begin
        rst_a = 1'b1; start_a = 1'b0; req_a = 4'd0; solved_a = 4'd0; q_a = 16'd999;
        rst_b = 1'b1; start_b = 1'b0; req_b = 4'd0; solved_b = 4'd0; q_b = 16'd0;

        // ---------------- instance A ----------------
        tick(2);
        chk("A_reset_outputs", {en_a, we_a, re_a, addr_a, data_a, strikes_a, sec_a, st_a, expl_a, def_a}, 64'd0);
        rst_a = 1'b0;
        req_a = 4'b1111;
        tick();
        req_a = 4'd0;
        chk("A_idle_state", 64'(st_a), 64'd0);

        qa.push_back(wr(TA, 16'd300));
        qa.push_back(wr(SA, 16'd0));
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("A_arm_t_state", 64'(st_a), 64'd1);
        tick();
        chk("A_arm_s_state", 64'(st_a), 64'd2);
        chk("A_sec_left_armed", 64'(sec_a), 64'd300);
        tick();
        chk("A_run_state", 64'(st_a), 64'd3);
        chk("A_strikes_zero", 64'(strikes_a), 64'd0);

        qa.push_back(wr(SA, 16'd1));
        req_a = 4'b0100; tick(); req_a = 4'd0;
        chk("A_strike_we", 64'(we_a), 64'd1);
        tick();
        chk("A_strikes_one", 64'(strikes_a), 64'd1);
        chk("A_not_exploded", 64'(expl_a), 64'd0);

        // Pointer now 3: grants module 3 then wraps to 0, explodes with module 1 left.
        qa.push_back(wr(SA, 16'd2));
        qa.push_back(wr(SA, 16'd3));
        req_a = 4'b1011; tick(); req_a = 4'd0;
        tick(2);
        chk("A_wrap_exploded_state", 64'(st_a), 64'd5);
        chk("A_wrap_exploded_flag", 64'(expl_a), 64'd1);
        chk("A_wrap_strikes", 64'(strikes_a), 64'd3);
        tick(3);

        rst_a = 1'b1; tick(); rst_a = 1'b0;
        qa.push_back(wr(TA, 16'd300));
        qa.push_back(wr(SA, 16'd0));
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(2);
        chk("A_rearm_run", 64'(st_a), 64'd3);
        qa.push_back(wr(SA, 16'd1));
        qa.push_back(wr(SA, 16'd2));
        qa.push_back(wr(SA, 16'd3));
        req_a = 4'b1011; tick(); req_a = 4'd0;
        tick(3);
        chk("A_burst_exploded_state", 64'(st_a), 64'd5);
        chk("A_burst_exploded_flag", 64'(expl_a), 64'd1);
        chk("A_burst_strikes", 64'(strikes_a), 64'd3);
        tick(3);

        // Restart from EXPLODED, then defuse.
        qa.push_back(wr(TA, 16'd300));
        qa.push_back(wr(SA, 16'd0));
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("A_restart_arm_t", 64'(st_a), 64'd1);
        chk("A_restart_clears_exploded", 64'(expl_a), 64'd0);
        tick(2);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("A_start_ignored_in_run", 64'(st_a), 64'd3);
        solved_a = 4'b0001;
        req_a = 4'b0001; tick(); req_a = 4'd0;
        tick();
        chk("A_solved_req_dropped", 64'(strikes_a), 64'd0);
        solved_a = 4'b0011; tick();
        solved_a = 4'b0111; tick();
        chk("A_partial_solved_run", 64'(st_a), 64'd3);
        solved_a = 4'b1111; tick();
        chk("A_defused_state", 64'(st_a), 64'd6);
        chk("A_defused_flag", 64'(def_a), 64'd1);
        req_a = 4'b1111; tick(); req_a = 4'd0;
        tick(2);
        chk("A_defused_strikes_frozen", 64'(strikes_a), 64'd0);
        chk("A_defused_hold", {st_a, def_a, expl_a}, {3'd6, 1'b1, 1'b0});

        // ---------------- instance B ----------------
        rst_b = 1'b0;
        tick();
        rd_vals.push_back(16'd57);
        rd_vals.push_back(16'd0);
        rd_vals.push_back(16'd100);
        qb.push_back(wr(TA, 16'd300));
        qb.push_back(wr(SA, 16'd0));
        qb.push_back(rd(TA));
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(2);
        chk("B_run_state", 64'(st_b), 64'd3);
        tick(3);
        chk("B_poll1_re", 64'(re_b), 64'd1);
        tick();
        chk("B_rd_wait_state", 64'(st_b), 64'd4);
        tick();
        chk("B_sec_left_57", 64'(sec_b), 64'd57);
        chk("B_back_to_run", 64'(st_b), 64'd3);
        qb.push_back(rd(TA));
        tick(2);
        chk("B_no_early_re", 64'(re_b), 64'd0);
        tick();
        chk("B_poll2_re", 64'(re_b), 64'd1);
        tick(2);
        chk("B_timeout_exploded", {st_b, expl_b}, {3'd5, 1'b1});
        chk("B_sec_left_zero", 64'(sec_b), 64'd0);

        qb.push_back(wr(TA, 16'd300));
        qb.push_back(wr(SA, 16'd0));
        qb.push_back(rd(TA));
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("B_restart_clears_exploded", 64'(expl_b), 64'd0);
        tick(5);
        chk("B_poll3_re", 64'(re_b), 64'd1);
        tick();
        chk("B_rd_wait_before_reset", 64'(st_b), 64'd4);
        rst_b = 1'b1;
        #1;
        chk("B_async_reset_outputs", {en_b, we_b, re_b, addr_b, data_b, strikes_b, sec_b, st_b, expl_b, def_b}, 64'd0);
        tick();
        rst_b = 1'b0;
        req_b = 4'b1111; tick(); req_b = 4'd0;
        chk("B_idle_after_reset", 64'(st_b), 64'd0);
        qb.push_back(wr(TA, 16'd300));
        qb.push_back(wr(SA, 16'd0));
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("B_rearm_t", 64'(st_b), 64'd1);
        tick();
        chk("B_rearm_s", 64'(st_b), 64'd2);
        tick();
        chk("B_rearm_run", {st_b, strikes_b, sec_b}, {3'd3, 2'd0, 16'd300});
        rst_b = 1'b1;
        tick(3);

        chk("A_scoreboard_drained", 64'(qa.size()), 64'd0);
        chk("B_scoreboard_drained", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
